// File: rtl/clkd_ratio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clkd_ratio_ctrl
// Description : Power-of-two clock divider controller. Free-running divide
//               counter, one selected divided clock plus enable pulse, and a
//               req/ack ratio change applied only at a full counter wrap.
//               Optional feature macro: CLKD_BYPASS_EN (sel=0 -> divide-by-1).
// Revision    : 1.0 - initial release
// ============================================================================
module clkd_ratio_ctrl #(
    parameter int MAX_LOG2 = 4,
    parameter int DEF_SEL  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [2:0] sel,
    output logic       ack,
    output logic       err,
    output logic       busy,
    output logic [2:0] cur_sel,
    output logic       div_clk,
    output logic       div_en
);

    typedef enum logic [0:0] {
        ST_IDLE       = 1'b0,
        ST_WAIT_ALIGN = 1'b1
    } state_t;

    localparam logic [MAX_LOG2-1:0] c_cnt_max = {MAX_LOG2{1'b1}};
    localparam logic [2:0]          c_def_sel = 3'(DEF_SEL);

    state_t                r_state_q,   w_state_d;
    logic [MAX_LOG2-1:0]   r_cnt_q,     w_cnt_d;
    logic [2:0]            r_cur_sel_q, w_cur_sel_d;
    logic [2:0]            r_pend_q,    w_pend_d;
    logic                  r_ack_q,     w_ack_d;
    logic                  r_err_q,     w_err_d;
    logic                  r_busy_q,    w_busy_d;
    logic                  r_div_clk_q, w_div_clk_d;
    logic                  r_div_en_q,  w_div_en_d;
    logic                  w_sel_legal;
    logic [MAX_LOG2-1:0]   w_mask;
    logic [MAX_LOG2-1:0]   w_msb;

`ifdef CLKD_BYPASS_EN
    assign w_sel_legal = (int'(sel) <= MAX_LOG2);
`else
    assign w_sel_legal = (sel != 3'd0) && (int'(sel) <= MAX_LOG2);
`endif

    always_comb begin
        w_cnt_d     = r_cnt_q + MAX_LOG2'(1);
        w_state_d   = r_state_q;
        w_cur_sel_d = r_cur_sel_q;
        w_pend_d    = r_pend_q;
        w_ack_d     = 1'b0;
        w_err_d     = 1'b0;
        w_busy_d    = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!w_sel_legal) begin
                        w_ack_d = 1'b1;
                        w_err_d = 1'b1;
                    end else if (sel == r_cur_sel_q) begin
                        w_ack_d = 1'b1;
                    end else begin
                        w_pend_d  = sel;
                        w_busy_d  = 1'b1;
                        w_state_d = ST_WAIT_ALIGN;
                    end
                end
            end
            ST_WAIT_ALIGN: begin
                // Switch on the wrap edge so the new ratio starts at cnt=0.
                if (r_cnt_q == c_cnt_max) begin
                    w_cur_sel_d = r_pend_q;
                    w_ack_d     = 1'b1;
                    w_state_d   = ST_IDLE;
                end else begin
                    w_busy_d = 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Divider taps use the post-edge ratio; a zero ratio yields an empty
    // mask (div_en always 1) and no msb tap (div_clk held 0).
    always_comb begin
        w_mask = '0;
        w_msb  = '0;
        for (int i = 0; i < MAX_LOG2; i++) begin
            w_mask[i] = (i < int'(w_cur_sel_d));
            w_msb[i]  = ((i + 1) == int'(w_cur_sel_d));
        end
        w_div_en_d  = ((w_cnt_d & w_mask) == w_mask);
        w_div_clk_d = |(w_cnt_d & w_msb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_cnt_q     <= '0;
            r_cur_sel_q <= c_def_sel;
            r_pend_q    <= c_def_sel;
            r_ack_q     <= 1'b0;
            r_err_q     <= 1'b0;
            r_busy_q    <= 1'b0;
            r_div_clk_q <= 1'b0;
            r_div_en_q  <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_cur_sel_q <= w_cur_sel_d;
            r_pend_q    <= w_pend_d;
            r_ack_q     <= w_ack_d;
            r_err_q     <= w_err_d;
            r_busy_q    <= w_busy_d;
            r_div_clk_q <= w_div_clk_d;
            r_div_en_q  <= w_div_en_d;
        end
    end

    assign ack     = r_ack_q;
    assign err     = r_err_q;
    assign busy    = r_busy_q;
    assign cur_sel = r_cur_sel_q;
    assign div_clk = r_div_clk_q;
    assign div_en  = r_div_en_q;

endmodule
`default_nettype wire

// File: tb/tb_clkd_ratio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clkd_ratio_ctrl
// Description : Self-checking bench for clkd_ratio_ctrl against a cycle model
//               built from counter arithmetic. Honors CLKD_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkd_ratio_ctrl;

    localparam int MAX_LOG2 = 4;
    localparam int DEF_SEL  = 1;
    localparam int N        = 1 << MAX_LOG2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [2:0] sel;
    logic       ack, err, busy, div_clk, div_en;
    logic [2:0] cur_sel;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt = 0, m_cur = DEF_SEL, m_pend = 0;
    bit m_busy = 0, m_ack = 0, m_err = 0, m_div_clk = 0, m_div_en = 0;

    clkd_ratio_ctrl #(.MAX_LOG2(MAX_LOG2), .DEF_SEL(DEF_SEL)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .sel     (sel),
        .ack     (ack),
        .err     (err),
        .busy    (busy),
        .cur_sel (cur_sel),
        .div_clk (div_clk),
        .div_en  (div_en)
    );

    always #5 clk = ~clk;

    function automatic bit sel_ok(input logic [2:0] s);
`ifdef CLKD_BYPASS_EN
        return int'(s) <= MAX_LOG2;
`else
        return (s != 3'd0) && (int'(s) <= MAX_LOG2);
`endif
    endfunction

    // Reference: divided clock is the upper half of each 2**cur_sel period of
    // the free-running count; enable marks the last count of the period.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_cur = DEF_SEL; m_pend = 0;
            m_busy = 0; m_ack = 0; m_err = 0;
        end else begin
            m_ack = 0; m_err = 0;
            if (m_busy) begin
                if (m_cnt == N - 1) begin
                    m_cur = m_pend; m_busy = 0; m_ack = 1;
                end
            end else if (req) begin
                if (!sel_ok(sel)) begin
                    m_ack = 1; m_err = 1;
                end else if (int'(sel) == m_cur) begin
                    m_ack = 1;
                end else begin
                    m_pend = int'(sel); m_busy = 1;
                end
            end
            m_cnt = (m_cnt + 1) % N;
        end
        m_div_clk = (m_cur == 0) ? 1'b0 : ((m_cnt % (1 << m_cur)) >= (1 << (m_cur - 1)));
        m_div_en  = (m_cnt % (1 << m_cur)) == ((1 << m_cur) - 1);
    end

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; sel = 3'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ack, err, busy, div_clk, div_en} !== 5'b0 || cur_sel !== 3'd1) begin
            n_errors++;
            $display("FAIL reset_state: got ack/err/busy/div_clk/div_en=%b%b%b%b%b cur_sel=%0d, want 00000 cur_sel=1",
                     ack, err, busy, div_clk, div_en, cur_sel);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ack, err, busy, cur_sel, div_clk, div_en} !== {m_ack, m_err, m_busy, 3'(m_cur), m_div_clk, m_div_en}) begin
                n_errors++;
                $display("FAIL reset_run cyc %0d: got %b%b%b sel=%0d clk=%b en=%b, want %b%b%b sel=%0d clk=%b en=%b",
                         c, ack, err, busy, cur_sel, div_clk, div_en, m_ack, m_err, m_busy, m_cur, m_div_clk, m_div_en);
            end
        end
        for (int c = 0; c < 4 && div_clk !== 1'b1; c++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ack, err, busy, div_clk, div_en} !== 5'b0 || cur_sel !== 3'd1) begin
            n_errors++;
            $display("FAIL async_reset: got ack/err/busy/div_clk/div_en=%b%b%b%b%b cur_sel=%0d, want 00000 cur_sel=1",
                     ack, err, busy, div_clk, div_en, cur_sel);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_switch();
        int ack_cnt = 0;
        int ack_cyc = -1;
        for (int c = 0; c < 2 * N && m_cnt != 3; c++) @(negedge clk);
        n_checks++;
        if (m_cnt != 3 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL switch_align: could not reach cnt=3 idle, got busy=%b", busy);
        end
        req = 1'b1; sel = 3'd3;
        @(negedge clk);
        req = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL switch_busy: got busy=%b, want 1", busy);
        end
        for (int c = 1; c < 40; c++) begin
            if (ack === 1'b1) begin ack_cnt++; if (ack_cyc < 0) ack_cyc = c; end
            n_checks++;
            if ({ack, err, busy, cur_sel, div_clk, div_en} !== {m_ack, m_err, m_busy, 3'(m_cur), m_div_clk, m_div_en}) begin
                n_errors++;
                $display("FAIL switch cyc %0d: got %b%b%b sel=%0d clk=%b en=%b, want %b%b%b sel=%0d clk=%b en=%b",
                         c, ack, err, busy, cur_sel, div_clk, div_en, m_ack, m_err, m_busy, m_cur, m_div_clk, m_div_en);
            end
            @(negedge clk);
        end
        n_checks++;
        if (ack_cnt != 1 || ack_cyc != 13 || cur_sel !== 3'd3) begin
            n_errors++;
            $display("FAIL switch_ack: got acks=%0d at cyc %0d cur_sel=%0d, want 1 at cyc 13 cur_sel=3",
                     ack_cnt, ack_cyc, cur_sel);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad [$];
        bad.push_back(3'd5);
        bad.push_back(3'd7);
`ifndef CLKD_BYPASS_EN
        bad.push_back(3'd0);
`endif
        foreach (bad[k]) begin
            int errs = 0;
            int busys = 0;
            req = 1'b1; sel = bad[k];
            @(negedge clk);
            req = 1'b0;
            for (int c = 0; c < 3; c++) begin
                errs += (err === 1'b1);
                busys += (busy === 1'b1);
                n_checks++;
                if ({ack, err, busy, cur_sel, div_clk, div_en} !== {m_ack, m_err, m_busy, 3'(m_cur), m_div_clk, m_div_en}) begin
                    n_errors++;
                    $display("FAIL illegal sel=%0d cyc %0d: got %b%b%b sel=%0d clk=%b en=%b, want %b%b%b sel=%0d clk=%b en=%b",
                             bad[k], c, ack, err, busy, cur_sel, div_clk, div_en, m_ack, m_err, m_busy, m_cur, m_div_clk, m_div_en);
                end
                @(negedge clk);
            end
            n_checks++;
            if (errs != 1 || busys != 0 || cur_sel !== 3'd3) begin
                n_errors++;
                $display("FAIL illegal_pulse sel=%0d: got err pulses=%0d busy cycles=%0d cur_sel=%0d, want 1 0 3",
                         bad[k], errs, busys, cur_sel);
            end
        end
    endtask

    task automatic test_same_sel();
        req = 1'b1; sel = cur_sel;
        @(negedge clk);
        req = 1'b0;
        n_checks++;
        if ({ack, err, busy} !== 3'b100 || cur_sel !== 3'd3) begin
            n_errors++;
            $display("FAIL same_sel: got ack/err/busy=%b%b%b cur_sel=%0d, want 100 cur_sel=3", ack, err, busy, cur_sel);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ack, err, busy, cur_sel, div_clk, div_en} !== {m_ack, m_err, m_busy, 3'(m_cur), m_div_clk, m_div_en}) begin
                n_errors++;
                $display("FAIL same_sel_run cyc %0d: got %b%b%b sel=%0d clk=%b en=%b, want %b%b%b sel=%0d clk=%b en=%b",
                         c, ack, err, busy, cur_sel, div_clk, div_en, m_ack, m_err, m_busy, m_cur, m_div_clk, m_div_en);
            end
        end
    endtask

    task automatic test_wait_ignore();
        int acks = 0;
        req = 1'b1; sel = 3'd4;
        for (int c = 0; c < N + 4; c++) begin
            @(negedge clk);
            req = 1'($urandom_range(0, 1)); sel = 3'd2;
            if (ack === 1'b1) acks++;
            n_checks++;
            if ({ack, err, busy, cur_sel, div_clk, div_en} !== {m_ack, m_err, m_busy, 3'(m_cur), m_div_clk, m_div_en}) begin
                n_errors++;
                $display("FAIL wait_ignore cyc %0d: got %b%b%b sel=%0d clk=%b en=%b, want %b%b%b sel=%0d clk=%b en=%b",
                         c, ack, err, busy, cur_sel, div_clk, div_en, m_ack, m_err, m_busy, m_cur, m_div_clk, m_div_en);
            end
            if (acks != 0) break;
        end
        req = 1'b0;
        n_checks++;
        if (acks != 1 || cur_sel !== 3'd4) begin
            n_errors++;
            $display("FAIL wait_first_pend: got acks=%0d cur_sel=%0d, want 1 cur_sel=4", acks, cur_sel);
        end
        @(negedge clk);
        for (int c = 0; c < 4 && busy === 1'b1; c++) @(negedge clk);
        req = 1'b1; sel = 3'd2;
        @(negedge clk);
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ack, busy} !== 2'b00 || cur_sel !== 3'(DEF_SEL)) begin
            n_errors++;
            $display("FAIL wait_reset: got ack/busy=%b%b cur_sel=%0d, want 00 cur_sel=%0d", ack, busy, cur_sel, DEF_SEL);
        end
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int c = 0; c < N + 4; c++) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 0 || cur_sel !== 3'(DEF_SEL)) begin
            n_errors++;
            $display("FAIL wait_reset_drop: got acks=%0d cur_sel=%0d, want 0 cur_sel=%0d", acks, cur_sel, DEF_SEL);
        end
    endtask

`ifdef CLKD_BYPASS_EN
    task automatic test_bypass();
        req = 1'b1; sel = 3'd0;
        @(negedge clk);
        req = 1'b0;
        for (int c = 0; c < N + 2 && ack !== 1'b1; c++) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({cur_sel, div_clk, div_en} !== {3'd0, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL bypass cyc %0d: got sel=%0d clk=%b en=%b, want sel=0 clk=0 en=1", c, cur_sel, div_clk, div_en);
            end
        end
        req = 1'b1; sel = 3'd2;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            req = 1'b0;
            n_checks++;
            if ({ack, err, busy, cur_sel, div_clk, div_en} !== {m_ack, m_err, m_busy, 3'(m_cur), m_div_clk, m_div_en}) begin
                n_errors++;
                $display("FAIL bypass_exit cyc %0d: got %b%b%b sel=%0d clk=%b en=%b, want %b%b%b sel=%0d clk=%b en=%b",
                         c, ack, err, busy, cur_sel, div_clk, div_en, m_ack, m_err, m_busy, m_cur, m_div_clk, m_div_en);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ack, err, busy, cur_sel, div_clk, div_en} !== {m_ack, m_err, m_busy, 3'(m_cur), m_div_clk, m_div_en}) begin
                n_errors++;
                $display("FAIL random cyc %0d: got %b%b%b sel=%0d clk=%b en=%b, want %b%b%b sel=%0d clk=%b en=%b",
                         c, ack, err, busy, cur_sel, div_clk, div_en, m_ack, m_err, m_busy, m_cur, m_div_clk, m_div_en);
            end
            req = ($urandom_range(0, 3) == 0);
            sel = 3'($urandom_range(0, 7));
        end
        req = 1'b0;
    endtask

    task automatic test_back_to_back();
        req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            sel = 3'($urandom_range(1, MAX_LOG2));
            @(negedge clk);
            n_checks++;
            if ({ack, err, busy, cur_sel, div_clk, div_en} !== {m_ack, m_err, m_busy, 3'(m_cur), m_div_clk, m_div_en}) begin
                n_errors++;
                $display("FAIL back_to_back cyc %0d: got %b%b%b sel=%0d clk=%b en=%b, want %b%b%b sel=%0d clk=%b en=%b",
                         c, ack, err, busy, cur_sel, div_clk, div_en, m_ack, m_err, m_busy, m_cur, m_div_clk, m_div_en);
            end
        end
        req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_switch();
        test_illegal();
        test_same_sel();
        test_wait_ignore();
`ifdef CLKD_BYPASS_EN
        test_bypass();
`endif
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
